// File: rtl/posit_err_collector.sv
// Response-side checker: pairs each accepted posit result with its golden word and queues
// |gold - result| into a small FIFO. Optional max tracking is enabled by POSIT_ERR_MAXTRACK_EN.
module posit_err_collector #(
   parameter int N  = 8,
   parameter int AW = 16,
   parameter int FD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] total,
   input  logic          res_valid,
   output logic          res_ready,
   input  logic [N-1:0]  res_data,
   output logic          gold_rd,
   output logic [AW-1:0] gold_addr,
   input  logic [N-1:0]  gold_data,
   output logic          diff_valid,
   input  logic          diff_ready,
   output logic [N-1:0]  diff_data,
   output logic [AW-1:0] err_cnt,
   output logic [AW-1:0] idx,
   output logic          busy,
   output logic          done,
`ifdef POSIT_ERR_MAXTRACK_EN
   output logic [N-1:0]  max_diff,
   output logic [AW-1:0] max_idx,
`endif
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(FD);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] total_q;
   logic [N-1:0]  stage;
   logic [N-1:0]  diff;
   logic          inflight;
   logic          accept;
   logic          push;
   logic          pop;
   logic [N-1:0]  mem [FD];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] occ;
`ifdef POSIT_ERR_MAXTRACK_EN
   logic [AW-1:0] stage_idx;
`endif

   // Both streams use valid/ready: a word moves on a rising edge where valid and ready are
   // both high; valid never depends on ready, and ready may be withdrawn at any cycle.
   assign accept     = res_valid && res_ready;
   assign push       = inflight;
   assign pop        = diff_valid && diff_ready;
   assign diff_valid = (count != '0);
   assign diff_data  = diff_valid ? mem[rd_ptr] : '0;
   assign diff       = (gold_data > stage) ? (gold_data - stage) : (stage - gold_data);
   assign gold_addr  = idx;
   assign dbg_state  = state_q;
   // An accepted read always lands in the FIFO next cycle, so its slot is reserved up front.
   assign occ        = count + CW'(inflight);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      res_ready = 1'b0;
      gold_rd   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: ;
         RUN: begin
            busy      = 1'b1;
            res_ready = !start && (idx < total_q) && (occ < CW'(FD));
            gold_rd   = res_ready && res_valid;
            if (gold_rd && ((idx + AW'(1)) == total_q)) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!inflight && ((count == '0) || ((count == CW'(1)) && pop))) state_d = DONE;
         end
         DONE: done = 1'b1;
         default: state_d = IDLE;
      endcase
      if (start) state_d = (total == '0) ? DONE : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst_n && !start && push) mem[wr_ptr] <= diff;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         total_q  <= rst_n ? total : '0;
         idx      <= '0;
         err_cnt  <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         if (!rst_n) stage <= '0;
`ifdef POSIT_ERR_MAXTRACK_EN
         max_diff  <= '0;
         max_idx   <= '0;
         if (!rst_n) stage_idx <= '0;
`endif
      end else begin
         if (accept) begin
            stage <= res_data;
            idx   <= idx + AW'(1);
`ifdef POSIT_ERR_MAXTRACK_EN
            stage_idx <= idx;
`endif
         end
         inflight <= accept;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if ((diff != '0) && (err_cnt != '1)) err_cnt <= err_cnt + AW'(1);
`ifdef POSIT_ERR_MAXTRACK_EN
            // Strict compare so ties keep the earlier index.
            if (diff > max_diff) begin
               max_diff <= diff;
               max_idx  <= stage_idx;
            end
`endif
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_posit_err_collector.sv
// Bench for posit_err_collector: queue-based reference model, directed scenarios and random runs.
// Build with POSIT_ERR_MAXTRACK_EN defined to also check max_diff/max_idx.
module tb_posit_err_collector;

   localparam int N  = 8;
   localparam int AW = 16;
   localparam int FD = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, res_valid, diff_ready;
   logic [AW-1:0] total;
   logic [N-1:0]  res_data, gold_data;
   logic          res_ready, gold_rd, diff_valid, busy, done;
   logic [AW-1:0] gold_addr, err_cnt, idx;
   logic [N-1:0]  diff_data;
   logic [1:0]    dbg_state;
`ifdef POSIT_ERR_MAXTRACK_EN
   logic [N-1:0]  max_diff;
   logic [AW-1:0] max_idx;
`endif

   always #5 clk = ~clk;

   posit_err_collector #(.N(N), .AW(AW), .FD(FD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .total(total),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .gold_rd(gold_rd), .gold_addr(gold_addr), .gold_data(gold_data),
      .diff_valid(diff_valid), .diff_ready(diff_ready), .diff_data(diff_data),
      .err_cnt(err_cnt), .idx(idx), .busy(busy), .done(done),
`ifdef POSIT_ERR_MAXTRACK_EN
      .max_diff(max_diff), .max_idx(max_idx),
`endif
      .dbg_state(dbg_state)
   );

   // reference model state
   int           m_phase = M_IDLE;
   int           m_total = 0, m_idx = 0, m_err = 0;
   logic [N-1:0] exp_q[$];
   int           pend_q[$];
   logic [N-1:0] m_max_diff = '0;
   int           m_max_idx = 0;
   logic         m_accept = 1'b0;

   logic [N-1:0] mem [256];
   logic [N-1:0] vec [256];
   logic [N-1:0] popped[$];
   int n_vec = 0, n_err = 0, cyc = 0;
   int acc_cnt = 0, rd_cnt = 0, last_pop_cyc = -1, done_cyc = -1;
   int first_acc = -1, first_dv = -1, first_addr = -1;
   int vprob = 100, rprob = 100;
   logic          rd_cap;
   logic [AW-1:0] addr_cap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic         e_ready;
      logic [N-1:0] e_data;
      e_ready  = (m_phase == M_RUN) && !start && (m_idx < m_total) &&
                 ((exp_q.size() + pend_q.size()) < FD);
      m_accept = e_ready && res_valid;
      e_data   = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("res_ready", res_ready, e_ready);
      chk("gold_rd", gold_rd, m_accept);
      if (m_accept) chk("gold_addr", gold_addr, m_idx);
      chk("diff_valid", diff_valid, exp_q.size() > 0);
      chk("diff_data", diff_data, e_data);
      chk("err_cnt", err_cnt, m_err);
      chk("idx", idx, m_idx);
      chk("busy", busy, (m_phase == M_RUN) || (m_phase == M_DRAIN));
      chk("done", done, m_phase == M_DONE);
`ifdef POSIT_ERR_MAXTRACK_EN
      chk("max_diff", max_diff, m_max_diff);
      chk("max_idx", max_idx, m_max_idx);
`endif
      if (res_valid && res_ready) begin
         acc_cnt++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (gold_rd) begin
         rd_cnt++;
         if (first_addr < 0) first_addr = int'(gold_addr);
      end
      if (diff_valid && first_dv < 0) first_dv = cyc;
      if (diff_valid && diff_ready) begin
         popped.push_back(diff_data);
         last_pop_cyc = cyc;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
   endtask

   task automatic model_update();
      logic [N-1:0] g, r, d;
      int           p;
      logic         had_pend;
      if (!rst_n || start) begin
         m_phase = !rst_n ? M_IDLE : ((total == '0) ? M_DONE : M_RUN);
         m_total = !rst_n ? 0 : int'(total);
         m_idx = 0; m_err = 0; m_max_diff = '0; m_max_idx = 0;
         exp_q.delete(); pend_q.delete();
         return;
      end
      had_pend = pend_q.size() > 0;
      if (exp_q.size() > 0 && diff_ready) void'(exp_q.pop_front());
      if (had_pend) begin
         p = pend_q.pop_front();
         g = mem[p % 256];
         r = vec[p % 256];
         d = (g > r) ? g - r : r - g;
         exp_q.push_back(d);
         if (d != 0 && m_err < 65535) m_err++;
         if (d > m_max_diff) begin
            m_max_diff = d;
            m_max_idx  = p;
         end
      end
      if (m_accept) begin
         pend_q.push_back(m_idx);
         m_idx++;
         if (m_idx == m_total) m_phase = M_DRAIN;
      end else if (m_phase == M_DRAIN && !had_pend && exp_q.size() == 0) begin
         m_phase = M_DONE;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      rd_cap   = gold_rd;
      addr_cap = gold_addr;
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      gold_data = rd_cap ? mem[addr_cap % 256] : 8'($urandom_range(255));
   endtask

   task automatic drive();
      res_valid  = ($urandom_range(99) < vprob);
      diff_ready = ($urandom_range(99) < rprob);
      res_data   = res_valid ? vec[m_idx % 256] : 8'($urandom_range(255));
   endtask

   task automatic do_start(input int t);
      start = 1'b1;
      total = AW'(t);
      drive();
      cycle();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      int n = 0;
      while (m_phase != M_DONE && n < budget) begin
         drive();
         cycle();
         n++;
      end
      chk("run_timeout", done, 1);
   endtask

   task automatic fill_random(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         mem[i] = 8'($urandom_range(255));
         vec[i] = ($urandom_range(1) == 0) ? mem[i] : 8'($urandom_range(255));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = '0;
         vec[i] = '0;
      end
      rst_n = 1'b0; start = 1'b0; total = '0; res_valid = 1'b0;
      diff_ready = 1'b0; res_data = '0; gold_data = '0;
      @(posedge clk);
      model_update();
      #1;
      repeat (2) cycle();
      chk("rst_res_ready", res_ready, 0);
      chk("rst_idx", idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      cycle();

      // exact match: four zero diffs, done one cycle after the last pop, 2-cycle latency
      mem[0] = 8'h40; mem[1] = 8'h20; mem[2] = 8'h00; mem[3] = 8'h80;
      for (int i = 0; i < 4; i++) vec[i] = mem[i];
      vprob = 100; rprob = 100;
      popped.delete(); done_cyc = -1; first_acc = -1; first_dv = -1;
      do_start(4);
      run_to_done(50);
      cycle();
      chk("exact_pops", popped.size(), 4);
      for (int i = 0; i < popped.size(); i++) chk("exact_diff", popped[i], 8'h00);
      chk("exact_err", err_cnt, 0);
      chk("exact_done_lag", done_cyc - last_pop_cyc, 1);
      chk("exact_latency", first_dv - first_acc, 2);

      // mismatch magnitudes
      mem[0] = 8'h40; vec[0] = 8'h41; mem[1] = 8'h30; vec[1] = 8'h10;
      popped.delete();
      do_start(2);
      run_to_done(50);
      chk("mis_pops", popped.size(), 2);
      if (popped.size() == 2) begin
         chk("mis_diff0", popped[0], 8'h01);
         chk("mis_diff1", popped[1], 8'h20);
      end
      chk("mis_err", err_cnt, 2);
`ifdef POSIT_ERR_MAXTRACK_EN
      chk("mis_max_diff", max_diff, 8'h20);
      chk("mis_max_idx", max_idx, 1);
`endif

      // backpressure: exactly FD accepts while the consumer stalls
      fill_random(8);
      vprob = 100; rprob = 0; acc_cnt = 0;
      popped.delete();
      do_start(8);
      repeat (10) begin
         drive();
         cycle();
      end
      chk("bp_accepts", acc_cnt, FD);
      chk("bp_ready_low", res_ready, 0);
      rprob = 100;
      run_to_done(60);
      chk("bp_total_pops", popped.size(), 8);
      chk("bp_total_accepts", acc_cnt, 8);

      // total == 0
      acc_cnt = 0; rd_cnt = 0;
      do_start(0);
      chk("zero_done", done, 1);
      repeat (3) begin
         drive();
         cycle();
      end
      chk("zero_accepts", acc_cnt, 0);
      chk("zero_reads", rd_cnt, 0);

      // restart after three accepts
      fill_random(8);
      do_start(8);
      for (int n = 0; n < 20 && m_idx < 3; n++) begin
         drive();
         cycle();
      end
      chk("rs_idx_before", idx, 3);
      first_addr = -1;
      do_start(5);
      chk("rs_idx", idx, 0);
      chk("rs_err", err_cnt, 0);
      chk("rs_fifo_empty", diff_valid, 0);
      run_to_done(60);
      chk("rs_first_addr", first_addr, 0);

      // reset during DRAIN
      fill_random(6);
      do_start(6);
      for (int n = 0; n < 30 && m_phase != M_DRAIN; n++) begin
         drive();
         cycle();
      end
      chk("rd_in_drain", busy, 1);
      rprob = 0;
      drive();
      cycle();
      rst_n = 1'b0;
      drive();
      cycle();
      rst_n = 1'b1;
      chk("rr_res_ready", res_ready, 0);
      chk("rr_gold_rd", gold_rd, 0);
      chk("rr_gold_addr", gold_addr, 0);
      chk("rr_diff_valid", diff_valid, 0);
      chk("rr_diff_data", diff_data, 0);
      chk("rr_err", err_cnt, 0);
      chk("rr_idx", idx, 0);
      chk("rr_busy", busy, 0);
      chk("rr_done", done, 0);
`ifdef POSIT_ERR_MAXTRACK_EN
      chk("rr_max_diff", max_diff, 0);
      chk("rr_max_idx", max_idx, 0);
`endif
      res_valid = 1'b0;
      cycle();

      // randomized runs with occasional restarts
      for (int run = 0; run < 40; run++) begin
         fill_random(32);
         vprob = $urandom_range(30, 100);
         rprob = $urandom_range(20, 100);
         do_start($urandom_range(1, 24));
         for (int n = 0; n < 400 && m_phase != M_DONE; n++) begin
            if ($urandom_range(199) == 0) do_start($urandom_range(0, 10));
            else begin
               drive();
               cycle();
            end
         end
         chk("rand_done", done, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/posit_err_collector.md
# posit_err_collector

Response-side checker for posit arithmetic units. It accepts a stream of posit results with a valid/ready handshake and fetches the matching golden word from a synchronous golden memory. It computes the unsigned absolute difference of the two bit patterns and queues each difference into an output FIFO for draining, while accumulating an error count. It sits downstream of a posit_mult instance in on-chip self-test, replacing file-based result comparison.

## Interface
- N, 8, posit word width
- AW, 16, result index / golden address / counter width
- FD, 4, difference FIFO depth (power of 2, ≥2)

Clock and reset (already decided): one clock, `clk`; reset `rst_n`, synchronous, active-low.

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse: clear and begin a run
- total  in  AW  number of results in the run, sampled on start
- res_valid  in  1  result word present
- res_ready  out  1  collector accepts result this cycle
- res_data  in  N  posit result under test
- gold_rd  out  1  golden read strobe
- gold_addr  out  AW  golden read address
- gold_data  in  N  golden word, valid the cycle after gold_rd
- diff_valid  out  1  FIFO head valid
- diff_ready  in  1  consumer pops head
- diff_data  out  N  |gold − result| for the head entry
- err_cnt  out  AW  count of nonzero differences, saturating at all-ones
- idx  out  AW  results accepted so far
- busy  out  1  state is RUN or DRAIN
- done  out  1  run complete, held until the next start

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DRAIN when idx == total after an accept.
  - DRAIN→DONE when no read is in flight and the FIFO is empty.
  - total == 0 on start: go to DONE directly, one cycle after start.
- start in any state clears idx, err_cnt, the FIFO and the in-flight flag, latches total, and enters RUN. It also clears the max-tracking registers when CFG is on. A result offered in the start cycle is not accepted.
- res_ready = (state == RUN) && (idx < total) && (fifo_count + inflight < FD).
- Accept (res_valid && res_ready):
  - res_data is captured into a stage register.
  - gold_rd = 1 and gold_addr = idx, both combinational in the same cycle.
  - idx increments and inflight is set.
- Cycle after accept: diff = (gold_data > stage) ? gold_data − stage : stage − gold_data, N-bit unsigned. The diff is written to the FIFO. If diff ≠ 0, err_cnt increments, saturating. inflight clears unless a new accept occurs in the same cycle.
- FIFO:
  - Pop on diff_valid && diff_ready.
  - Simultaneous push and pop when full is legal, because push capacity was reserved by res_ready.
  - The FIFO never overflows.
  - Pop when empty is ignored.
- Back-to-back accepts at one per cycle are sustained while diff_ready stays high.

## Timing
- Reset values: res_ready 0, gold_rd 0, gold_addr 0, diff_valid 0, diff_data 0, err_cnt 0, idx 0, busy 0, done 0, state IDLE. max_diff and max_idx reset to 0.
- Latency: accept at cycle t → diff_valid at t+2 with that entry, if the FIFO was empty.
- err_cnt updates at t+2.
- done rises one cycle after the last FIFO pop in DRAIN.
- rst_n low mid-run aborts immediately. Outstanding gold_data is discarded.

## Configuration
- POSIT_ERR_MAXTRACK_EN defined:
  - Adds outputs max_diff (N) and max_idx (AW).
  - On each FIFO write with diff > max_diff, update max_diff and set max_idx to the index of that result.
  - Ties keep the earlier index.
- Undefined: these ports and registers are absent.

## Test plan
- Exact match: total=4, results 0x40,0x20,0x00,0x80 equal to golden → four diffs of 0x00, err_cnt=0, done after the last pop.
- Mismatch and magnitude: result 0x41 vs gold 0x40, result 0x10 vs gold 0x30 → diffs 0x01 and 0x20, err_cnt=2. With MAXTRACK: max_diff=0x20, max_idx=1.
- Backpressure: diff_ready=0, res_valid=1 held, FD=4 → exactly 4 accepts, then res_ready=0. Raising diff_ready resumes at one per cycle with no loss and order preserved.
- total=0: start → done=1 one cycle later, res_ready never asserts, no gold_rd.
- Restart mid-run: start issued after 3 of 8 accepts → FIFO empties, idx=0, err_cnt=0, next accept reads gold_addr 0.
- Reset mid-run: rst_n low for one cycle in DRAIN → all outputs at reset values the next cycle, state IDLE.
